// File: rtl/perceptron_pkg.sv
// Shared types and arithmetic helpers for the perceptron trainer.
package perceptron_pkg;

    typedef enum logic [2:0] {IDLE, MAC, UPDATE, EPOCH, DONE} state_t;

    // Wide enough for N_DIM products plus the bias preset without overflow.
    function automatic int acc_width(input int data_w, input int w_w, input int n_dim);
        return data_w + w_w + $clog2(n_dim + 1);
    endfunction

    // Signed add clamped to the range of a w-bit two's-complement value.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = 33'(a) + 33'(b);
        hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (w - 1));
        if (sum > hi) return hi[31:0];
        if (sum < lo) return lo[31:0];
        return sum[31:0];
    endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample-load handshake between a host and the perceptron trainer.
interface perceptron_trainer_if #(
    parameter int N_DIM  = 2,
    parameter int DATA_W = 8
);
    logic                      load_valid;
    logic                      load_ready;
    logic [N_DIM*DATA_W-1:0]   load_x;
    logic                      load_label;

    modport master (output load_valid, load_x, load_label, input load_ready);
    modport slave  (input load_valid, load_x, load_label, output load_ready);
endinterface

// File: rtl/perceptron_mac.sv
// Signed multiply-accumulate, one product per cycle; clr loads the preset
// (plus the current product when en is also high).
module perceptron_mac #(
    parameter int DATA_W = 8,
    parameter int W_W    = 8,
    parameter int ACC_W  = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [ACC_W-1:0]  preset,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [W_W-1:0]    w,
    output logic signed [ACC_W-1:0]  acc
);
    localparam int PROD_W = DATA_W + W_W;

    logic signed [PROD_W-1:0] prod;
    assign prod = PROD_W'(x) * PROD_W'(w);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= en ? preset + ACC_W'(prod) : preset;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end
endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: sample buffer, training FSM and saturating weight update.
// Define PERCEPTRON_BIAS_EN to build with a trainable bias term.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_DIM      = 2,
    parameter int N_SAMPLES  = 4,
    parameter int DATA_W     = 8,
    parameter int W_W        = 8,
    parameter int LR_SHIFT   = 0,
    parameter int MAX_EPOCHS = 15
) (
    input  logic                               clk,
    input  logic                               rst,
    perceptron_trainer_if.slave                load_bus,
    input  logic                               clear,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic                               converged,
    output logic [$clog2(MAX_EPOCHS+1)-1:0]    epoch_cnt,
    output logic [N_DIM*W_W-1:0]               weights,
    output logic [W_W-1:0]                     bias
);
    localparam int ACC_W = acc_width(DATA_W, W_W, N_DIM);
    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int DIM_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;
    localparam int EP_W  = $clog2(MAX_EPOCHS + 1);
    localparam logic [DIM_W-1:0] LAST_DIM   = DIM_W'(N_DIM - 1);
    localparam logic [EP_W-1:0]  LAST_EPOCH = EP_W'(MAX_EPOCHS - 1);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(N_SAMPLES);

    state_t state, state_next;
    logic [CNT_W-1:0] n_loaded, sample_idx, err_cnt;
    logic [DIM_W-1:0] dim_idx;
    logic             load_fire, last_sample, y_hat, delta_pos, delta_neg, mis, upd_en;

    logic [N_DIM*DATA_W-1:0]  x_mem [N_SAMPLES];
    logic [N_SAMPLES-1:0]     label_mem;
    logic [N_DIM*DATA_W-1:0]  cur_x;
    logic                     cur_label;
    logic signed [DATA_W-1:0] x_d;
    logic signed [W_W-1:0]    w_q   [N_DIM];
    logic signed [W_W-1:0]    w_upd [N_DIM];
    logic signed [31:0]       term  [N_DIM];
    logic signed [ACC_W-1:0]  acc, preset;

    assign load_bus.load_ready = (state == IDLE) && (n_loaded != FULL);
    assign load_fire   = load_bus.load_valid && load_bus.load_ready && !clear;
    assign last_sample = (sample_idx == n_loaded - CNT_W'(1));
    assign cur_x       = x_mem[sample_idx[IDX_W-1:0]];
    assign cur_label   = label_mem[sample_idx[IDX_W-1:0]];
    assign x_d         = cur_x[dim_idx*DATA_W +: DATA_W];
    assign y_hat       = !acc[ACC_W-1] && (acc != '0);
    assign delta_pos   = cur_label && !y_hat;
    assign delta_neg   = !cur_label && y_hat;
    assign mis         = delta_pos || delta_neg;
    assign upd_en      = (state == UPDATE) && mis;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:   if (start && !clear) state_next = (n_loaded == '0) ? DONE : MAC;
            MAC: begin
                busy = 1'b1;
                if (dim_idx == LAST_DIM) state_next = UPDATE;
            end
            UPDATE: begin
                busy       = 1'b1;
                state_next = last_sample ? EPOCH : MAC;
            end
            EPOCH: begin
                busy       = 1'b1;
                state_next = (err_cnt == '0 || epoch_cnt == LAST_EPOCH) ? DONE : MAC;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sample storage has no reset; n_loaded alone marks which entries are valid.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            x_mem[n_loaded[IDX_W-1:0]]     <= load_bus.load_x;
            label_mem[n_loaded[IDX_W-1:0]] <= load_bus.load_label;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_loaded   <= '0;
            sample_idx <= '0;
            dim_idx    <= '0;
            err_cnt    <= '0;
            epoch_cnt  <= '0;
            converged  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        n_loaded <= '0;
                    end else begin
                        if (load_fire) n_loaded <= n_loaded + CNT_W'(1);
                        if (start) begin
                            sample_idx <= '0;
                            dim_idx    <= '0;
                            err_cnt    <= '0;
                            epoch_cnt  <= '0;
                            converged  <= (n_loaded == '0);
                        end
                    end
                end
                MAC: dim_idx <= (dim_idx == LAST_DIM) ? '0 : dim_idx + DIM_W'(1);
                UPDATE: begin
                    if (mis) err_cnt <= err_cnt + CNT_W'(1);
                    sample_idx <= last_sample ? '0 : sample_idx + CNT_W'(1);
                end
                EPOCH: begin
                    epoch_cnt <= epoch_cnt + EP_W'(1);
                    if (err_cnt == '0)                converged <= 1'b1;
                    else if (epoch_cnt != LAST_EPOCH) err_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    // All dimensions of the current sample are updated together in the UPDATE cycle.
    always_comb begin
        for (int d = 0; d < N_DIM; d++) begin
            term[d] = 32'($signed(cur_x[d*DATA_W +: DATA_W])) >>> LR_SHIFT;
            if (delta_neg) term[d] = -term[d];
            w_upd[d] = W_W'(sat_add(32'(w_q[d]), term[d], W_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < N_DIM; d++) w_q[d] <= '0;
        end else if (upd_en) begin
            for (int d = 0; d < N_DIM; d++) w_q[d] <= w_upd[d];
        end
    end

    always_comb begin
        weights = '0;
        for (int d = 0; d < N_DIM; d++) weights[d*W_W +: W_W] = w_q[d];
    end

`ifdef PERCEPTRON_BIAS_EN
    logic signed [W_W-1:0] bias_q;

    always_ff @(posedge clk) begin
        if (rst)
            bias_q <= '0;
        else if (upd_en)
            bias_q <= W_W'(sat_add(32'(bias_q), delta_neg ? -32'sd1 : 32'sd1, W_W));
    end

    assign preset = ACC_W'(bias_q);
    assign bias   = bias_q;
`else
    assign preset = '0;
    assign bias   = '0;
`endif

    perceptron_mac #(
        .DATA_W (DATA_W),
        .W_W    (W_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state == MAC) && (dim_idx == '0)),
        .preset (preset),
        .en     (state == MAC),
        .x      (x_d),
        .w      (w_q[dim_idx]),
        .acc    (acc)
    );
endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer (N_DIM=2, 8-bit data/weights, 4 samples, 4 epochs).
module tb_perceptron_trainer;
    logic        clk = 1'b0;
    logic        rst, clear, start;
    logic        busy, done, converged;
    logic [2:0]  epoch_cnt;
    logic [15:0] weights;
    logic [7:0]  bias;
    int          n_checks = 0;
    int          n_fail   = 0;

`ifdef PERCEPTRON_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif

    perceptron_trainer_if #(.N_DIM(2), .DATA_W(8)) load_bus ();

    perceptron_trainer #(
        .N_DIM(2), .N_SAMPLES(4), .DATA_W(8), .W_W(8), .LR_SHIFT(0), .MAX_EPOCHS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_bus  (load_bus),
        .clear     (clear),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .converged (converged),
        .epoch_cnt (epoch_cnt),
        .weights   (weights),
        .bias      (bias)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] x0, input logic [7:0] x1, input logic label,
                        output bit accepted);
        @(negedge clk);
        accepted = load_bus.load_ready;
        load_bus.load_valid = 1'b1;
        load_bus.load_x     = {x1, x0};
        load_bus.load_label = label;
        @(negedge clk);
        load_bus.load_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that accepts start.
    task automatic run_train(input string tag, input int exp_cycles, input bit inject,
                             output bit saw_busy);
        int cycles;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cycles   = 1;
        saw_busy = 1'b0;
        while (!done && cycles < 100) begin
            saw_busy |= busy;
            if (inject && cycles == 2) begin
                check({tag, " busy mid-run"}, busy, 1);
                check({tag, " load_ready mid-run"}, load_bus.load_ready, 0);
                start               = 1'b1;
                load_bus.load_valid = 1'b1;
                load_bus.load_x     = 16'h7f7f;
                load_bus.load_label = 1'b1;
            end
            @(negedge clk);
            start               = 1'b0;
            load_bus.load_valid = 1'b0;
            cycles++;
        end
        check({tag, " done cycle"}, cycles, exp_cycles);
        check({tag, " busy at done"}, busy, 0);
    endtask

    initial begin
        bit acc_ok, saw_busy, saw_done;
        int n_acc;
        rst = 1'b1; clear = 1'b0; start = 1'b0;
        load_bus.load_valid = 1'b0; load_bus.load_x = '0; load_bus.load_label = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset load_ready", load_bus.load_ready, 1);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset converged", converged, 0);
        check("reset epoch_cnt", epoch_cnt, 0);
        check("reset weights", weights, 0);
        check("reset bias", bias, 0);

        // Single sample (2,3) label 1: one corrective epoch, then a clean one.
        push(8'd2, 8'd3, 1'b1, acc_ok);
        check("t1 push accepted", acc_ok, 1);
        run_train("t1", 9, 1'b0, saw_busy);
        check("t1 converged", converged, 1);
        check("t1 epoch_cnt", epoch_cnt, 2);
        check("t1 weights", weights, 16'h0302);
        check("t1 bias", bias, BIAS_ON ? 32'd1 : 32'd0);

        // Overfill the buffer, then clear it.
        pulse_clear();
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            push(8'(i), 8'(-i), 1'(i % 2), acc_ok);
            n_acc += int'(acc_ok);
        end
        check("t3 accepted pushes", n_acc, 4);
        check("t3 load_ready full", load_bus.load_ready, 0);
        pulse_clear();
        check("t3 load_ready after clear", load_bus.load_ready, 1);
        check("t3 weights kept", weights, 16'h0302);

        // Start and load while busy are ignored; rerun timing proves n_loaded stayed 1.
        pulse_clear();
        push(8'd1, 8'd1, 1'b1, acc_ok);
        run_train("t6", 5, 1'b1, saw_busy);
        check("t6 converged", converged, 1);
        check("t6 epoch_cnt", epoch_cnt, 1);
        check("t6 weights", weights, 16'h0302);
        run_train("t6 rerun", 5, 1'b0, saw_busy);

        // Reset in the first MAC cycle of a run.
        pulse_clear();
        push(8'd2, 8'd3, 1'b1, acc_ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 busy after rst", busy, 0);
        check("t5 weights after rst", weights, 0);
        check("t5 load_ready after rst", load_bus.load_ready, 1);
        check("t5 converged after rst", converged, 0);
        check("t5 epoch_cnt after rst", epoch_cnt, 0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("t5 no done pulse", saw_done, 0);

        // Buffer was emptied by reset: start goes straight to DONE.
        run_train("t4", 1, 1'b0, saw_busy);
        check("t4 busy never", saw_busy, 0);
        check("t4 converged", converged, 1);
        check("t4 epoch_cnt", epoch_cnt, 0);

        // Zero vector, label 1: only a bias can ever fix it.
        push(8'd0, 8'd0, 1'b1, acc_ok);
        run_train("t2", BIAS_ON ? 9 : 17, 1'b0, saw_busy);
        check("t2 converged", converged, BIAS_ON ? 32'd1 : 32'd0);
        check("t2 epoch_cnt", epoch_cnt, BIAS_ON ? 32'd2 : 32'd4);
        check("t2 weights", weights, 0);
        check("t2 bias", bias, BIAS_ON ? 32'd1 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
